// File: rtl/ram_to_axis_reader_pkg.sv
// ram_to_axis_reader_pkg
// Shared types and helpers for the RAM-to-stream reader.
//   state_e  : reader FSM encoding, also exported on the debug state port
//   ceil_div : number of whole beats needed to carry a byte count
package ram_to_axis_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] ceil_div(input logic [31:0] len, input logic [31:0] bytes);
    return (len + bytes - 32'd1) / bytes;
  endfunction

endpackage

// File: rtl/ram_to_axis_fifo.sv
// ram_to_axis_fifo
// Small synchronous FIFO holding read beats (data plus framing tags) until the
// stream consumer accepts them.
//   i_clk, i_rst (async, active-low)
//   i_push, i_data : write one entry (caller never pushes when full)
//   i_pop          : remove head entry (caller never pops when empty)
//   o_data         : head entry, o_count : occupancy, o_empty : no entries
module ram_to_axis_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_push,
  input  logic [WIDTH-1:0]    i_data,
  input  logic                i_pop,
  output logic [WIDTH-1:0]    o_data,
  output logic [CNT_BITS-1:0] o_count,
  output logic                o_empty
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
    end
    if (i_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end
    // Push and pop together leave the occupancy unchanged.
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/ram_to_axis_reader.sv
// ram_to_axis_reader
// On a command, reads ceil(i_len/DAT_BYTS) consecutive RAM words (address
// wrapping modulo RAM_DEPTH) and emits them as one framed stream packet.
//   i_clk, i_rst (async, active-low)
//   i_start/i_addr/i_len/i_ctl : command, accepted only while o_busy==0
//   o_busy, o_done             : command in progress / one-cycle completion pulse
//   o_state                    : FSM state for observation
//   o_ram_*/i_ram_q            : RAM read port, q valid RD_LAT cycles after en
//   o_axi_*/i_axi_rdy          : stream source
// Stream handshake: a beat transfers on a cycle where o_axi_val && i_axi_rdy;
// while o_axi_val is high and i_axi_rdy low every o_axi_* field is held, and
// o_axi_val never drops before the beat transfers.
module ram_to_axis_reader
  import ram_to_axis_reader_pkg::*;
#(
  parameter int DAT_BYTS   = 8,
  parameter int CTL_BITS   = 8,
  parameter int RAM_DEPTH  = 128,
  parameter int RD_LAT     = 2,
  parameter int LEN_BITS   = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int DAT_BITS  = DAT_BYTS * 8,
  localparam int MOD_BITS  = $clog2(DAT_BYTS),
  localparam int ADDR_BITS = $clog2(RAM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [LEN_BITS-1:0]  i_len,
  input  logic [CTL_BITS-1:0]  i_ctl,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_state,
  output logic [ADDR_BITS-1:0] o_ram_a,
  output logic                 o_ram_en,
  output logic                 o_ram_re,
  output logic                 o_ram_we,
  output logic [DAT_BITS-1:0]  o_ram_d,
  input  logic [DAT_BITS-1:0]  i_ram_q,
  output logic                 o_axi_val,
  output logic                 o_axi_sop,
  output logic                 o_axi_eop,
  output logic                 o_axi_err,
  output logic [CTL_BITS-1:0]  o_axi_ctl,
  output logic [DAT_BITS-1:0]  o_axi_dat,
  output logic [MOD_BITS-1:0]  o_axi_mod,
  input  logic                 i_axi_rdy
);

  localparam int TAG_BITS = 2 + MOD_BITS;            // {sop, eop, mod}
  localparam int FIFO_W   = DAT_BITS + TAG_BITS;
  localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [LEN_BITS-1:0]   words_q, words_d;
  logic [LEN_BITS-1:0]   rd_idx_q, rd_idx_d;
  logic [CTL_BITS-1:0]   ctl_q, ctl_d;
  logic [MOD_BITS-1:0]   mod_q, mod_d;
  // Read-return pipeline: bit i set means a read issued i+1 cycles ago.
  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic [TAG_BITS-1:0]   tag_q [RD_LAT];
  logic [TAG_BITS-1:0]   tag_d [RD_LAT];

  logic                  issue;
  logic                  is_last;
  logic [TAG_BITS-1:0]   issue_tag;
  logic [CNT_BITS-1:0]   in_flight;
  logic [CNT_BITS:0]     credit_used;
  logic                  credit_ok;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_val;
  logic [FIFO_W-1:0]     fifo_head;
  logic [CNT_BITS-1:0]   fifo_count;
  logic                  head_sop;
  logic                  head_eop;
  logic [MOD_BITS-1:0]   head_mod;
  logic [DAT_BITS-1:0]   head_dat;

  assign fifo_val = !fifo_empty;
  assign fifo_pop = fifo_val && i_axi_rdy;
  assign head_sop = fifo_head[FIFO_W-1];
  assign head_eop = fifo_head[FIFO_W-2];
  assign head_mod = fifo_head[FIFO_W-3 -: MOD_BITS];
  assign head_dat = fifo_head[DAT_BITS-1:0];

  // Credit: every read either still in the pipeline or already buffered owns
  // a FIFO slot, so a returning q always finds room.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      in_flight = in_flight + CNT_BITS'(vld_q[i]);
    end
    credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
    credit_ok   = credit_used < (CNT_BITS + 1)'(FIFO_DEPTH);
  end

  assign is_last   = (rd_idx_q == words_q - LEN_BITS'(1));
  assign issue_tag = {(rd_idx_q == '0), is_last, (is_last ? mod_q : '0)};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    words_d  = words_q;
    rd_idx_d = rd_idx_q;
    ctl_d    = ctl_q;
    mod_d    = mod_q;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (i_start) begin
          addr_d   = i_addr;
          words_d  = LEN_BITS'(ceil_div(32'(i_len), 32'(DAT_BYTS)));
          mod_d    = MOD_BITS'(32'(i_len) % 32'(DAT_BYTS));
          ctl_d    = i_ctl;
          rd_idx_d = '0;
          state_d  = (i_len != '0) ? ST_READ : ST_DONE;
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          issue    = 1'b1;
          addr_d   = (addr_q == ADDR_BITS'(RAM_DEPTH - 1)) ? '0 : addr_q + ADDR_BITS'(1);
          rd_idx_d = rd_idx_q + LEN_BITS'(1);
          if (is_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && head_eop) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d[0] = issue;
    tag_d[0] = issue_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      words_q  <= '0;
      rd_idx_q <= '0;
      ctl_q    <= '0;
      mod_q    <= '0;
      vld_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
      rd_idx_q <= rd_idx_d;
      ctl_q    <= ctl_d;
      mod_q    <= mod_d;
      vld_q    <= vld_d;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  // q is valid in the cycle the oldest pipeline stage is set.
  assign fifo_push = vld_q[RD_LAT-1];

  ram_to_axis_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_data  ({tag_q[RD_LAT-1], i_ram_q}),
    .i_pop   (fifo_pop),
    .o_data  (fifo_head),
    .o_count (fifo_count),
    .o_empty (fifo_empty)
  );

  assign o_busy  = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign o_done  = (state_q == ST_DONE);
  assign o_state = state_q;

  assign o_ram_a  = issue ? addr_q : '0;
  assign o_ram_en = issue;
  assign o_ram_re = issue;
  assign o_ram_we = 1'b0;
  assign o_ram_d  = '0;

  // Fields are forced to zero whenever no beat is offered.
  assign o_axi_val = fifo_val;
  assign o_axi_sop = fifo_val && head_sop;
  assign o_axi_eop = fifo_val && head_eop;
  assign o_axi_err = 1'b0;
  assign o_axi_mod = fifo_val ? head_mod : '0;
  assign o_axi_dat = fifo_val ? head_dat : '0;
  assign o_axi_ctl = fifo_val ? ctl_q : '0;

endmodule
